catch_game_ctl: RTL and testbench

CATCH_GAME_CTL -- requirements
Module: catch_game_ctl

---
 rtl/game_pkg.sv | 22 ++
 rtl/catch_check.sv | 46 ++++
 rtl/catch_game_ctl.sv | 155 +++++++++++++++
 tb/tb_catch_game_ctl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the catch game controller: state encodings, the
// lives limit and a small bit-count helper for the per-channel event flags.
package game_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_START = 2'b01,
    ST_END   = 2'b10,
    ST_PLAY  = 2'b11
  } game_state_t;

  localparam int LIVES_MAX = 7;
  localparam int N_OBJ_MAX = 4;

  function automatic logic [2:0] count_ones(input logic [N_OBJ_MAX-1:0] v);
    count_ones = 3'd0;
    for (int i = 0; i < N_OBJ_MAX; i++) begin
      count_ones = count_ones + 3'(v[i]);
    end
  endfunction

endpackage

// File: rtl/catch_check.sv
// Per-channel basket/object overlap test. Gives this cycle's caught/missed
// decision and a registered copy used for next-cycle event pulses.
module catch_check #(
  parameter int COORD_W  = 12,
  parameter int OBJ_W    = 48,
  parameter int BASKET_W = 48
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               play_en,
  input  logic               fin,
  input  logic [COORD_W-1:0] basket_x,
  input  logic [COORD_W-1:0] obj_x,
  output logic               caught,
  output logic               missed,
  output logic               caught_q,
  output logic               missed_q
);

  localparam logic [COORD_W:0] OBJ_EXT    = (COORD_W+1)'(OBJ_W);
  localparam logic [COORD_W:0] BASKET_EXT = (COORD_W+1)'(BASKET_W);

  logic [COORD_W:0] obj_right;
  logic [COORD_W:0] basket_right;
  logic             overlap;

  // One extra bit keeps the right edges from wrapping near the screen edge.
  assign obj_right    = {1'b0, obj_x} + OBJ_EXT;
  assign basket_right = {1'b0, basket_x} + BASKET_EXT;
  assign overlap      = ({1'b0, basket_x} <= obj_right) &&
                        (basket_right >= {1'b0, obj_x});

  assign caught = fin && play_en && overlap;
  assign missed = fin && play_en && !overlap;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      caught_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      caught_q <= caught;
      missed_q <= missed;
    end
  end

endmodule

// File: rtl/catch_game_ctl.sv
// Catch game controller: button edge detection, game-state FSM, score/lives
// bookkeeping and per-channel respawn requests for N_OBJ falling objects.
module catch_game_ctl
  import game_pkg::*;
#(
  parameter int N_OBJ    = 2,
  parameter int COORD_W  = 12,
  parameter int SCORE_W  = 16,
  parameter int LIVES    = 3,
  parameter int OBJ_W    = 48,
  parameter int BASKET_W = 48
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     start_btn,
  input  logic                     pause_btn,
  input  logic                     restart_btn,
  input  logic [COORD_W-1:0]       basket_x,
  input  logic [N_OBJ*COORD_W-1:0] obj_x,
  input  logic [N_OBJ-1:0]         obj_fin,
  output logic [1:0]               state,
  output logic                     play_en,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       best,
  output logic [2:0]               lives,
  output logic [N_OBJ-1:0]         respawn,
  output logic                     hit,
  output logic                     miss
);

  localparam int LIVES_CLAMP = (LIVES > LIVES_MAX) ? LIVES_MAX :
                               (LIVES < 1) ? 1 : LIVES;
  localparam logic [2:0]           LIVES_INIT = 3'(LIVES_CLAMP);
  localparam logic [SCORE_W+2:0]   SCORE_MAX  = {3'b000, {SCORE_W{1'b1}}};

  game_state_t        state_r, state_nxt;
  logic [SCORE_W-1:0] score_r, score_nxt;
  logic [SCORE_W-1:0] best_r, best_nxt;
  logic [2:0]         lives_r, lives_nxt;

  // Button sample and history registers; an action fires the cycle after sampling.
  logic start_s, start_h, pause_s, pause_h, restart_s, restart_h;
  logic start_rise, pause_rise, restart_rise;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      start_s   <= 1'b0;
      start_h   <= 1'b0;
      pause_s   <= 1'b0;
      pause_h   <= 1'b0;
      restart_s <= 1'b0;
      restart_h <= 1'b0;
    end else begin
      start_s   <= start_btn;
      start_h   <= start_s;
      pause_s   <= pause_btn;
      pause_h   <= pause_s;
      restart_s <= restart_btn;
      restart_h <= restart_s;
    end
  end

  assign start_rise   = start_s && !start_h;
  assign pause_rise   = pause_s && !pause_h;
  assign restart_rise = restart_s && !restart_h;

  logic [N_OBJ-1:0] caught, missed, caught_q, missed_q;

  for (genvar i = 0; i < N_OBJ; i++) begin : g_chk
    catch_check #(
      .COORD_W (COORD_W),
      .OBJ_W   (OBJ_W),
      .BASKET_W(BASKET_W)
    ) u_chk (
      .pclk    (pclk),
      .rst     (rst),
      .play_en (play_en),
      .fin     (obj_fin[i]),
      .basket_x(basket_x),
      .obj_x   (obj_x[i*COORD_W +: COORD_W]),
      .caught  (caught[i]),
      .missed  (missed[i]),
      .caught_q(caught_q[i]),
      .missed_q(missed_q[i])
    );
  end

  logic [2:0]         n_hit, n_miss;
  logic [SCORE_W+2:0] score_sum;

  assign n_hit     = count_ones(N_OBJ_MAX'(caught));
  assign n_miss    = count_ones(N_OBJ_MAX'(missed));
  assign score_sum = {3'b000, score_r} + (SCORE_W+3)'(n_hit);

  always_comb begin
    state_nxt = state_r;
    score_nxt = score_r;
    best_nxt  = best_r;
    lives_nxt = lives_r;
    case (state_r)
      ST_START: begin
        if (start_rise) begin
          state_nxt = ST_PLAY;
          score_nxt = '0;
          lives_nxt = LIVES_INIT;
        end
      end
      ST_PLAY: begin
        score_nxt = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                            : score_sum[SCORE_W-1:0];
        lives_nxt = (n_miss >= lives_r) ? 3'd0 : lives_r - n_miss;
        // Losing the last life outranks a simultaneous pause request.
        if (n_miss != 3'd0 && n_miss >= lives_r) begin
          state_nxt = ST_END;
          if (score_nxt > best_r) best_nxt = score_nxt;
        end else if (pause_rise) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_rise) state_nxt = ST_PLAY;
      end
      ST_END: begin
        if (restart_rise) state_nxt = ST_START;
      end
      default: state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_START;
      score_r <= '0;
      best_r  <= '0;
      lives_r <= LIVES_INIT;
    end else begin
      state_r <= state_nxt;
      score_r <= score_nxt;
      best_r  <= best_nxt;
      lives_r <= lives_nxt;
    end
  end

  assign state   = state_r;
  assign play_en = (state_r == ST_PLAY);
  assign score   = score_r;
  assign best    = best_r;
  assign lives   = lives_r;
  assign hit     = |caught_q;
  assign miss    = |missed_q;
  // Flags are only non-zero right after a PLAY cycle, so END here means the
  // same update just ended the game and no object should restart.
  assign respawn = (caught_q | missed_q) & {N_OBJ{state_r != ST_END}};

endmodule

// File: tb/tb_catch_game_ctl.sv
// Directed bench for catch_game_ctl with hand-computed expectations for
// button handling, catch/miss scoring, saturation, game over and reset.
module tb_catch_game_ctl;

  localparam int N_OBJ   = 2;
  localparam int COORD_W = 12;
  localparam int SCORE_W = 16;

  logic                     pclk;
  logic                     rst;
  logic                     start_btn, pause_btn, restart_btn;
  logic [COORD_W-1:0]       basket_x;
  logic [COORD_W-1:0]       x0, x1;
  logic [N_OBJ*COORD_W-1:0] obj_x;
  logic [N_OBJ-1:0]         obj_fin;
  logic [1:0]               state;
  logic                     play_en;
  logic [SCORE_W-1:0]       score, best;
  logic [2:0]               lives;
  logic [N_OBJ-1:0]         respawn;
  logic                     hit, miss;

  int n_checks = 0;
  int n_pass   = 0;

  assign obj_x = {x1, x0};

  catch_game_ctl #(
    .N_OBJ  (N_OBJ),
    .COORD_W(COORD_W),
    .SCORE_W(SCORE_W),
    .LIVES  (3)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .restart_btn(restart_btn),
    .basket_x   (basket_x),
    .obj_x      (obj_x),
    .obj_fin    (obj_fin),
    .state      (state),
    .play_en    (play_en),
    .score      (score),
    .best       (best),
    .lives      (lives),
    .respawn    (respawn),
    .hit        (hit),
    .miss       (miss)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // drivers
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: start_btn   = v;
      1: pause_btn   = v;
      default: restart_btn = v;
    endcase
  endtask

  // Hold a button for two cycles (sample, then act), release, settle one cycle.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick();
    tick();
    set_btn(b, 1'b0);
    tick();
  endtask

  task automatic fin_cycle(input logic [N_OBJ-1:0] f);
    obj_fin = f;
    tick();
    obj_fin = '0;
  endtask

  initial begin
    rst = 1'b1;
    start_btn = 0; pause_btn = 0; restart_btn = 0;
    basket_x = 12'd100; x0 = 12'd120; x1 = 12'd120; obj_fin = '0;
    #2 rst = 1'b0;
    tick(); tick();
    check("rst_state", 32'(state), 32'h1);
    check("rst_score", 32'(score), 0);
    check("rst_best", 32'(best), 0);
    check("rst_lives", 32'(lives), 3);
    check("rst_play_en", 32'(play_en), 0);
    check("rst_respawn", 32'(respawn), 0);
    check("rst_hit_miss", 32'({hit, miss}), 0);
    rst = 1'b1;
    tick();

    // game 1
    press(0);
    check("start_state", 32'(state), 32'h3);
    check("start_play_en", 32'(play_en), 1);
    check("start_lives", 32'(lives), 3);
    fin_cycle(2'b01);
    check("catch_score", 32'(score), 1);
    check("catch_hit", 32'(hit), 1);
    check("catch_miss", 32'(miss), 0);
    check("catch_respawn", 32'(respawn), 32'h1);
    tick();
    check("hit_one_cycle", 32'(hit), 0);
    check("respawn_one_cycle", 32'(respawn), 0);

    press(1);
    check("pause_state", 32'(state), 32'h0);
    check("pause_play_en", 32'(play_en), 0);
    fin_cycle(2'b01);
    check("pause_fin_score", 32'(score), 1);
    check("pause_fin_hit", 32'(hit), 0);
    check("pause_fin_respawn", 32'(respawn), 0);
    press(1);
    check("unpause_state", 32'(state), 32'h3);
    press(2);
    check("restart_in_play", 32'(state), 32'h3);

    basket_x = 12'd600; x0 = 12'd100;
    fin_cycle(2'b01);
    check("miss1_lives", 32'(lives), 2);
    check("miss1_miss", 32'(miss), 1);
    check("miss1_respawn", 32'(respawn), 32'h1);
    fin_cycle(2'b01);
    check("miss2_lives", 32'(lives), 1);
    // last-life miss with a coincident pause edge
    pause_btn = 1'b1;
    tick();
    fin_cycle(2'b01);
    pause_btn = 1'b0;
    check("miss3_lives", 32'(lives), 0);
    check("miss3_state_end", 32'(state), 32'h2);
    check("miss3_no_respawn", 32'(respawn), 0);
    check("miss3_miss", 32'(miss), 1);
    check("end_best", 32'(best), 1);
    tick();
    press(2);
    check("restart_state", 32'(state), 32'h1);
    press(0);
    check("restart_play", 32'(state), 32'h3);
    check("restart_score", 32'(score), 0);
    check("restart_lives", 32'(lives), 3);
    check("restart_best", 32'(best), 1);

    // game 2
    basket_x = 12'd100; x0 = 12'd120; x1 = 12'd600;
    fin_cycle(2'b11);
    check("mixed_score", 32'(score), 1);
    check("mixed_lives", 32'(lives), 2);
    check("mixed_hit_miss", 32'({hit, miss}), 32'h3);
    check("mixed_respawn", 32'(respawn), 32'h3);
    // catch with a coincident pause edge
    pause_btn = 1'b1;
    tick();
    fin_cycle(2'b01);
    pause_btn = 1'b0;
    check("fin_pause_state", 32'(state), 32'h0);
    check("fin_pause_score", 32'(score), 2);
    check("fin_pause_respawn", 32'(respawn), 32'h1);
    tick();
    press(1);
    check("unpause2_state", 32'(state), 32'h3);
    x0 = 12'd52;
    fin_cycle(2'b01);
    check("left_edge_catch", 32'(score), 3);
    x0 = 12'd148;
    fin_cycle(2'b01);
    check("right_edge_catch", 32'(score), 4);
    x0 = 12'd51;
    fin_cycle(2'b01);
    check("left_edge_miss_lives", 32'(lives), 1);
    check("left_edge_miss_score", 32'(score), 4);
    x0 = 12'd120;
    fin_cycle(2'b01);
    check("score5", 32'(score), 5);
    tick();
    #3 rst = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'h1);
    check("midrst_score", 32'(score), 0);
    check("midrst_best", 32'(best), 0);
    check("midrst_lives", 32'(lives), 3);
    tick();
    rst = 1'b1;
    tick();

    // game 3: saturation
    press(0);
    x0 = 12'd120; x1 = 12'd120;
    obj_fin = 2'b11;
    repeat (32767) tick();
    obj_fin = '0;
    check("preload_score", 32'(score), 32'hFFFE);
    fin_cycle(2'b11);
    check("sat_score", 32'(score), 32'hFFFF);
    fin_cycle(2'b11);
    check("sat_hold", 32'(score), 32'hFFFF);
    x1 = 12'd149;
    fin_cycle(2'b10);
    check("right_edge_miss_lives", 32'(lives), 2);
    check("right_edge_miss_flags", 32'({hit, miss}), 32'h1);
    check("right_edge_miss_score", 32'(score), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
